menu_nav: RTL and testbench
===========================

# menu_nav

Parametrised selection-menu navigator for the UI front end. It converts debounced, synchronised up/down/select buttons into a bounded menu index. It supports saturating or wrap-around modes, hold-to-auto-repeat, and a separate confirmed-selection register. It sits between the button debouncers and the screen/mode logic, and generalises the two-bit fixed-range menu to any choice count.

## Interface
- NUM_CHOICES, 4, number of menu entries (>=1); index range 0..NUM_CHOICES-1
- RESET_CHOICE, 0, index loaded into choice and confirmed on reset (< NUM_CHOICES)
- WRAP, 0, 0 = saturate at ends; 1 = wrap top->0 and 0->top
- HOLD_CYCLES, 25_000_000, cycles a button must stay held before the first auto-repeat step (>=1)
- REPEAT_CYCLES, 5_000_000, cycles between successive auto-repeat steps (>=1)
- IDX_W (localparam), max(1,$clog2(NUM_CHOICES)), index width
- clk_in  input  1  system clock; one clock domain
- rst_in  input  1  asynchronous, active-low reset
- btn_up  input  1  level, debounced, synchronous to clk_in
- btn_down  input  1  level, debounced, synchronous to clk_in
- btn_select  input  1  level, debounced, synchronous to clk_in
- lock_in  input  1  high: moves and selects ignored; repeat timers keep running
- choice  output  IDX_W  current highlighted index (registered)
- confirmed  output  IDX_W  last selected index (registered)
- moved  output  1  one-cycle pulse, coincident with every change of choice
- selected  output  1  one-cycle pulse, coincident with every load of confirmed

## Operation
- Each of up/down has an independent repeater FSM: IDLE, HOLD, REPEAT.
  - IDLE -> HOLD on sampled rising edge; emits step.
  - HOLD: counter runs; at HOLD_CYCLES after the press edge, emits step -> REPEAT.
  - REPEAT: emits step every REPEAT_CYCLES.
  - Button low in any state -> IDLE, counter cleared, no step.
- Rising edge is detected against a registered previous sample, which resets to 0. A button held through reset release therefore counts as a new press.
- Step arbitration, per cycle:
  - up only: choice+1.
  - down only: choice-1.
  - both or neither: no change.
- Boundaries:
  - WRAP=0: up at NUM_CHOICES-1 and down at 0 leave choice unchanged, with no moved pulse.
  - WRAP=1: up at the top goes to 0 and down at 0 goes to the top; moved asserts.
  - NUM_CHOICES=1: choice is constant and moved never asserts.
- Select: rising edge of btn_select (no auto-repeat) loads confirmed with the pre-update choice and pulses selected. This holds even if choice moves on the same edge.
- lock_in high suppresses choice/confirmed updates and pulses. Steps occurring while locked are lost, not queued.
- Reset values: choice=RESET_CHOICE, confirmed=RESET_CHOICE, moved=0, selected=0, repeaters IDLE, previous samples 0.

## Timing
- Button first sampled high at edge k:
  - repeater step is registered high after edge k;
  - choice/moved update at edge k+1, so there is a 2-edge latency from the first sampling edge.
- Continuous hold produces steps at sampling edges k, k+HOLD_CYCLES, k+HOLD_CYCLES+REPEAT_CYCLES, and so on. Each step is reflected one edge later.
- Select follows the same timing: the edge at k loads confirmed and pulses selected at edge k+1.
- The asynchronous reset clears all state immediately, with no clock required. Release is synchronous to the next clk_in edge by the upstream reset synchroniser.
- Counter width: $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1). The counter must never overflow while the button is held indefinitely.

## Structure
- menu_pkg holds:
  - the repeater state enum (RPT_IDLE, RPT_HOLD, RPT_REPEAT);
  - a function computing the next index given step direction, NUM_CHOICES and WRAP.
- Sub-module btn_repeater (params HOLD_CYCLES, REPEAT_CYCLES; ports clk_in, rst_in, btn, step) is instantiated twice, for up and down.
- Select uses a plain edge detector in the top level.
- Elaboration-time assertions: NUM_CHOICES>=1, RESET_CHOICE<NUM_CHOICES, HOLD_CYCLES>=1, REPEAT_CYCLES>=1.

## Test plan
All scenarios use NUM_CHOICES=5, HOLD_CYCLES=4, REPEAT_CYCLES=2, RESET_CHOICE=0 unless stated.
- **Tap up:** WRAP=0, single 1-cycle up press at edge k -> choice 0->1 at edge k+1, moved high exactly one cycle, confirmed stays 0.
- **Hold to saturate:** WRAP=0, up held for edges k..k+11 -> steps at k, k+4, k+6, k+8, k+10. Choice goes 1, 2, 3, 4, then stays 4; exactly 4 moved pulses.
- **Wrap both ways:** WRAP=1, choice=4 -> tap up gives 0; then tap down gives 4; moved pulses on both.
- **Simultaneous events:**
  - up and down rising on the same edge -> choice unchanged, no moved pulse;
  - select and up rising on the same edge at choice=2 -> confirmed=2, choice=3, selected and moved both pulse.
- **Lock:** lock_in high during an up tap and a select tap -> choice, confirmed and pulses unchanged. Lock low, then a new tap -> normal move.
- **Reset mid-operation:** rst_in low while up is in REPEAT at choice=3 -> choice=0, confirmed=0, pulses 0 without a clock edge. Up still held at reset release -> treated as a new press, choice=1 two edges later.

Source files
------------

// File: rtl/menu_pkg.sv
// Shared types and index arithmetic for the menu navigator.
package menu_pkg;

  typedef enum logic [1:0] {RPT_IDLE, RPT_HOLD, RPT_REPEAT} rpt_state_e;

  // Next index for a single up (up=1) or down (up=0) step; ends saturate or wrap.
  function automatic int unsigned next_idx(input int unsigned cur, input logic up,
                                           input int unsigned n, input logic wrap);
    if (up) begin
      if (cur >= n - 1) return wrap ? 32'd0 : cur;
      return cur + 1;
    end
    if (cur == 0) return wrap ? n - 1 : 32'd0;
    return cur - 1;
  endfunction

endpackage

// File: rtl/btn_repeater.sv
// Hold-to-repeat for one button: a step on the press edge, another after
// HOLD_CYCLES, then one every REPEAT_CYCLES while the button stays held.
module btn_repeater
  import menu_pkg::*;
#(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn,
  output logic step
);

  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  rpt_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_prev, w_step_nxt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= RPT_IDLE;
      r_cnt   <= '0;
      r_prev  <= 1'b0;
      step    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prev  <= btn;
      step    <= w_step_nxt;
    end
  end

  // r_cnt holds edges-since-entry minus one, so it tops out below MAXC.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = 1'b0;
    if (!btn) begin
      w_state_nxt = RPT_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        RPT_IDLE: begin
          if (!r_prev) begin
            w_state_nxt = RPT_HOLD;
            w_cnt_nxt   = '0;
            w_step_nxt  = 1'b1;
          end
        end
        RPT_HOLD: begin
          if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
            w_state_nxt = RPT_REPEAT;
            w_cnt_nxt   = '0;
            w_step_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        RPT_REPEAT: begin
          if (r_cnt == CW'(REPEAT_CYCLES - 1)) begin
            w_cnt_nxt  = '0;
            w_step_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = RPT_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/menu_nav.sv
// Menu index navigator: up/down repeaters drive a bounded index, select
// latches the index the user was looking at into confirmed.
module menu_nav
  import menu_pkg::*;
#(
  parameter int NUM_CHOICES   = 4,
  parameter int RESET_CHOICE  = 0,
  parameter int WRAP          = 0,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  localparam int IDX_W = (NUM_CHOICES > 1) ? $clog2(NUM_CHOICES) : 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_select,
  input  logic             lock_in,
  output logic [IDX_W-1:0] choice,
  output logic [IDX_W-1:0] confirmed,
  output logic             moved,
  output logic             selected
);

  if (NUM_CHOICES < 1) begin : g_bad_n
    $error("menu_nav: NUM_CHOICES must be >= 1");
  end
  if (RESET_CHOICE >= NUM_CHOICES) begin : g_bad_rst
    $error("menu_nav: RESET_CHOICE must be < NUM_CHOICES");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("menu_nav: HOLD_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rpt
    $error("menu_nav: REPEAT_CYCLES must be >= 1");
  end

  logic             w_step_up, w_step_dn, w_move, w_sel;
  logic             r_sel_prev, r_sel_step;
  logic [IDX_W-1:0] w_next;

  btn_repeater #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_rpt_up (
    .clk_in(clk_in), .rst_in(rst_in), .btn(btn_up), .step(w_step_up)
  );

  btn_repeater #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_rpt_dn (
    .clk_in(clk_in), .rst_in(rst_in), .btn(btn_down), .step(w_step_dn)
  );

  // Opposing steps cancel; a blocked end step is not a move.
  always_comb begin
    w_next = IDX_W'(next_idx(32'(choice), w_step_up, NUM_CHOICES, WRAP != 0));
    w_move = !lock_in && (w_step_up ^ w_step_dn) && (w_next != choice);
    w_sel  = !lock_in && r_sel_step;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      choice     <= IDX_W'(RESET_CHOICE);
      confirmed  <= IDX_W'(RESET_CHOICE);
      moved      <= 1'b0;
      selected   <= 1'b0;
      r_sel_prev <= 1'b0;
      r_sel_step <= 1'b0;
    end else begin
      r_sel_prev <= btn_select;
      r_sel_step <= btn_select & ~r_sel_prev;
      moved      <= w_move;
      selected   <= w_sel;
      if (w_move) choice <= w_next;
      // Captures the pre-move index even when choice changes on this edge.
      if (w_sel) confirmed <= choice;
    end
  end

endmodule

// File: tb/tb_menu_nav.sv
// Scoreboard bench: a cycle-level model of the navigator pushes expected
// outputs per sampling edge for three configurations sharing one stimulus.
module tb_menu_nav;

  localparam int H = 4;
  localparam int R = 2;
  localparam int NC [3] = '{5, 5, 1};
  localparam int WR [3] = '{0, 1, 0};

  logic clk = 1'b0;
  logic rst_n, up, dn, sel, lock;
  logic [2:0] ch0, cf0, ch1, cf1;
  logic       ch2, cf2;
  logic [2:0] mv, sl;

  always #5 clk = ~clk;

  menu_nav #(.NUM_CHOICES(5), .RESET_CHOICE(0), .WRAP(0), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) u_sat (
    .clk_in(clk), .rst_in(rst_n), .btn_up(up), .btn_down(dn), .btn_select(sel), .lock_in(lock),
    .choice(ch0), .confirmed(cf0), .moved(mv[0]), .selected(sl[0]));

  menu_nav #(.NUM_CHOICES(5), .RESET_CHOICE(0), .WRAP(1), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) u_wrap (
    .clk_in(clk), .rst_in(rst_n), .btn_up(up), .btn_down(dn), .btn_select(sel), .lock_in(lock),
    .choice(ch1), .confirmed(cf1), .moved(mv[1]), .selected(sl[1]));

  menu_nav #(.NUM_CHOICES(1), .RESET_CHOICE(0), .WRAP(0), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) u_one (
    .clk_in(clk), .rst_in(rst_n), .btn_up(up), .btn_down(dn), .btn_select(sel), .lock_in(lock),
    .choice(ch2), .confirmed(cf2), .moved(mv[2]), .selected(sl[2]));

  typedef struct {
    int ch [3];
    int cf [3];
    int mv [3];
    int sl [3];
  } exp_t;

  exp_t q [$];
  int checks = 0;
  int errors = 0;
  int cycn = 0;

  int m_ch [3];
  int m_cf [3];
  int mv_cnt [3];
  int sl_cnt [3];
  bit p_up, p_dn, p_sel, prev_sel;
  int h_up, h_dn;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int g_ch(input int i);
    case (i)
      0: return int'(ch0);
      1: return int'(ch1);
      default: return int'(ch2);
    endcase
  endfunction

  function automatic int g_cf(input int i);
    case (i)
      0: return int'(cf0);
      1: return int'(cf1);
      default: return int'(cf2);
    endcase
  endfunction

  function automatic int mnext(input int c, input bit u, input int n, input bit w);
    if (u) return (c == n - 1) ? (w ? 0 : c) : c + 1;
    return (c == 0) ? (w ? n - 1 : 0) : c - 1;
  endfunction

  // h counts edges since the press edge; steps at 0, H, H+R, H+2R, ...
  function automatic bit rpt(input bit b, inout int h);
    if (!b) begin
      h = -1;
      return 1'b0;
    end
    if (h < 0) begin
      h = 0;
      return 1'b1;
    end
    h++;
    return (h == H) || (h > H && ((h - H) % R) == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ch[i] = 0;
      m_cf[i] = 0;
    end
    p_up = 0; p_dn = 0; p_sel = 0; prev_sel = 0;
    h_up = -1; h_dn = -1;
  endtask

  task automatic model_edge(input bit u, input bit d, input bit s, input bit l, output exp_t e);
    int nx, old;
    for (int i = 0; i < 3; i++) begin
      e.mv[i] = 0;
      e.sl[i] = 0;
      old = m_ch[i];
      if (!l && (p_up ^ p_dn)) begin
        nx = mnext(m_ch[i], p_up, NC[i], WR[i] != 0);
        if (nx != m_ch[i]) begin
          m_ch[i] = nx;
          e.mv[i] = 1;
        end
      end
      if (!l && p_sel) begin
        m_cf[i] = old;
        e.sl[i] = 1;
      end
      e.ch[i] = m_ch[i];
      e.cf[i] = m_cf[i];
    end
    p_up = rpt(u, h_up);
    p_dn = rpt(d, h_dn);
    p_sel = s && !prev_sel;
    prev_sel = s;
  endtask

  // Entered and left at a negedge; covers exactly one sampling edge.
  task automatic cyc(input bit u, input bit d, input bit s, input bit l);
    exp_t e, g;
    up = u; dn = d; sel = s; lock = l;
    model_edge(u, d, s, l, e);
    q.push_back(e);
    @(posedge clk);
    #1;
    cycn++;
    g = q.pop_front();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("c%0d d%0d choice", cycn, i), g_ch(i), g.ch[i]);
      chk($sformatf("c%0d d%0d confirmed", cycn, i), g_cf(i), g.cf[i]);
      chk($sformatf("c%0d d%0d moved", cycn, i), int'(mv[i]), g.mv[i]);
      chk($sformatf("c%0d d%0d selected", cycn, i), int'(sl[i]), g.sl[i]);
      mv_cnt[i] += int'(mv[i]);
      sl_cnt[i] += int'(sl[i]);
    end
    @(negedge clk);
  endtask

  // Asserted at a negedge: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s d%0d choice", tag, i), g_ch(i), m_ch[i]);
      chk($sformatf("%s d%0d confirmed", tag, i), g_cf(i), m_cf[i]);
      chk($sformatf("%s d%0d moved", tag, i), int'(mv[i]), 0);
      chk($sformatf("%s d%0d selected", tag, i), int'(sl[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 3; i++) begin
      mv_cnt[i] = 0;
      sl_cnt[i] = 0;
    end
  endtask

  initial begin
    rst_n = 1'b0; up = 0; dn = 0; sel = 0; lock = 0;
    model_reset();
    clr_cnt();
    @(negedge clk);
    do_reset("init");
    cyc(0, 0, 0, 0);

    // Tap up
    clr_cnt();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("tap choice", int'(ch0), 1);
    chk("tap confirmed", int'(cf0), 0);
    chk("tap moves", mv_cnt[0], 1);

    // Hold to saturate / wrap around
    do_reset("pre_hold");
    clr_cnt();
    repeat (12) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("hold sat choice", int'(ch0), 4);
    chk("hold sat moves", mv_cnt[0], 4);
    chk("hold wrap choice", int'(ch1), 0);
    chk("hold wrap moves", mv_cnt[1], 5);
    chk("one-choice moves", mv_cnt[2], 0);

    // Wrap both ways
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("wrap down", int'(ch1), 4);
    clr_cnt();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("wrap up", int'(ch1), 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("wrap down again", int'(ch1), 4);
    chk("wrap moves", mv_cnt[1], 2);

    // Up and down on the same edge cancel
    clr_cnt();
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("both sat moves", mv_cnt[0], 0);
    chk("both wrap moves", mv_cnt[1], 0);

    // Select and up on the same edge at choice 2
    do_reset("pre_sel");
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    clr_cnt();
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("sel+up choice", int'(ch0), 3);
    chk("sel+up confirmed", int'(cf0), 2);
    chk("sel+up moves", mv_cnt[0], 1);
    chk("sel+up selects", sl_cnt[0], 1);

    // Lock drops taps
    clr_cnt();
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("lock choice", int'(ch0), 3);
    chk("lock confirmed", int'(cf0), 2);
    chk("lock moves", mv_cnt[0], 0);
    chk("lock selects", sl_cnt[0], 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("unlock choice", int'(ch0), 4);

    // Reset while up is in REPEAT, up still held at release
    do_reset("pre_rpt");
    repeat (8) cyc(1, 0, 0, 0);
    chk("repeat choice", int'(ch0), 3);
    do_reset("mid_rpt");
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("held-through-reset choice", int'(ch0), 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
